nios_altmemddr_0_ex_lfsr_seq: RTL
=================================

NIOS_ALTMEMDDR_0_EX_LFSR_SEQ -- requirements
Module: nios_altmemddr_0_ex_lfsr_seq

Interface
REQ-001 SHALL have parameter SEED, default 32, 8-bit LFSR seed value, also driven on lfsr_ldata.
REQ-002 SHALL have parameter ADDR_W, default 8; the test covers 2^ADDR_W words at addresses 0..2^ADDR_W-1.
REQ-003 SHALL have ports, one per line:
 clk  in  1  single clock, all logic on rising edge
 reset  in  1  synchronous, active-high
 start  in  1  begin a write-then-verify pass; sampled only in IDLE
 abort  in  1  terminate the current pass
 busy  out  1  high in any state except IDLE
 done  out  1  one-cycle pulse when a pass completes or aborts
 pass  out  1  last pass completed with zero mismatches
 fail  out  1  last pass had at least one mismatch, or was aborted
 err_count  out  8  mismatch count, saturates at 255
 first_err_addr  out  ADDR_W  address of first mismatch
 wr_req  out  1  write request; held until wr_ack
 wr_ack  in  1  write accepted
 rd_req  out  1  read request; held until rd_ack
 rd_ack  in  1  read accepted
 rd_valid  in  1  read data valid
 rd_data  in  8  read data
 mem_addr  out  ADDR_W  address for wr_req/rd_req
 wr_data  out  8  equals lfsr_data
 lfsr_enable  out  1  to LFSR enable (low holds the LFSR at seed)
 lfsr_pause  out  1  to LFSR pause
 lfsr_load  out  1  to LFSR load
 lfsr_ldata  out  8  constant SEED[7:0]
 lfsr_data  in  8  current LFSR value (x^8 Galois, taps into bits 2,3,4)

Function
REQ-004 SHALL implement states IDLE, WRITE, REWIND, READ, WAIT_DATA, FINISH.
REQ-005 IDLE: lfsr_enable=0, wr_req=rd_req=0, mem_addr=0; start=1 -> WRITE next cycle.
REQ-006 WRITE: wr_req=1, lfsr_enable=1; when wr_ack=1, mem_addr increments and lfsr_pause=0 for that cycle only.
REQ-007 lfsr_pause SHALL be 1 in every cycle except WRITE with wr_ack=1, or WAIT_DATA with rd_valid=1.
REQ-008 WRITE with wr_ack at mem_addr=2^ADDR_W-1 -> REWIND; mem_addr wraps to 0.
REQ-009 REWIND lasts exactly one cycle: lfsr_load=1, lfsr_enable=1, then -> READ; lfsr_load SHALL be 0 in all other states.
REQ-010 READ: rd_req=1; rd_ack=1 -> WAIT_DATA; rd_req deasserts the next cycle; only one read is outstanding.
REQ-011 WAIT_DATA: rd_valid=1 -> compare rd_data with lfsr_data; on mismatch, err_count increments (saturating at 255); on the first mismatch of a pass, first_err_addr := mem_addr.
REQ-012 WAIT_DATA rd_valid at last address -> FINISH; otherwise mem_addr+1 -> READ.
REQ-013 rd_valid outside WAIT_DATA and wr_ack/rd_ack without a pending request SHALL be ignored.
REQ-014 FINISH lasts one cycle: done=1; pass=(err_count==0), fail=(err_count!=0); -> IDLE.
REQ-015 pass/fail/err_count/first_err_addr SHALL hold until the next accepted start, which clears all four in the cycle WRITE is entered.
REQ-016 abort=1 in any non-IDLE state -> FINISH with fail=1, pass=0, regardless of err_count; any outstanding request is dropped. Abort takes priority over simultaneous ack/valid.
REQ-017 start while busy SHALL be ignored; start and abort together in IDLE: abort ignored, start accepted.
REQ-018 Latency: start to first wr_req = 1 cycle; last rd_valid to done = 1 cycle.

Reset
REQ-019 reset=1 SHALL force IDLE in the same edge, mid-operation included, with outputs busy=done=pass=fail=0, err_count=0, first_err_addr=0, mem_addr=0, wr_req=rd_req=0, lfsr_enable=0, lfsr_pause=1, lfsr_load=0.

Verification
REQ-020 ADDR_W=2, memory model with zero-wait acks: start -> writes 0x20,0x40,0x80,0x1D to addresses 0..3, one REWIND load pulse, 4 reads, done pulse, pass=1, err_count=0.
REQ-021 Same run with address 2 read data corrupted to 0x00 -> fail=1, err_count=1, first_err_addr=2.
REQ-022 Memory returning 0xFF always, ADDR_W=9 -> err_count saturates at 255, fail=1.
REQ-023 wr_ack delayed 3 cycles per write -> LFSR advances exactly once per ack, wr_data stable while wr_req is held.
REQ-024 abort asserted during WAIT_DATA with simultaneous rd_valid -> next cycle FINISH, done=1, fail=1, pass=0; then IDLE.
REQ-025 reset asserted mid-WRITE -> next cycle all outputs at REQ-019 values; a subsequent start runs a complete pass from address 0 with seed 0x20.

Source files
------------

// File: rtl/nios_altmemddr_0_ex_lfsr_seq.sv
// Write-then-verify memory sequencer: streams an external LFSR into 2^ADDR_W words,
// rewinds the LFSR to its seed, reads every word back and counts mismatches.
module nios_altmemddr_0_ex_lfsr_seq #(
  parameter logic [7:0] SEED   = 8'd32,
  parameter int         ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        wr_data,
  output logic              lfsr_enable,
  output logic              lfsr_pause,
  output logic              lfsr_load,
  output logic [7:0]        lfsr_ldata,
  input  logic [7:0]        lfsr_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_REWIND,
    S_READ,
    S_WAIT_DATA,
    S_FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic [7:0]        err_q, err_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              mismatch;

  assign mismatch = (rd_data != lfsr_data);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    first_err_d = first_err_q;
    err_d       = err_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    lfsr_pause  = 1'b1;

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d     = S_WRITE;
          err_d       = 8'd0;
          first_err_d = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
        end
      end
      S_WRITE: begin
        if (wr_ack) begin
          lfsr_pause = 1'b0;
          addr_d     = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) state_d = S_REWIND;
        end
      end
      S_REWIND: state_d = S_READ;
      S_READ: begin
        if (rd_ack) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (rd_valid) begin
          lfsr_pause = 1'b0;
          if (mismatch) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (err_q == 8'd0)  first_err_d = addr_q;
          end
          if (addr_q == LAST_ADDR) begin
            state_d = S_FINISH;
            addr_d  = '0;
            pass_d  = (err_d == 8'd0);
            fail_d  = (err_d != 8'd0);
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides any same-cycle ack/valid; FINISH already ends the pass.
    if (abort && (state_q != S_IDLE) && (state_q != S_FINISH)) begin
      state_d     = S_FINISH;
      addr_d      = '0;
      err_d       = err_q;
      first_err_d = first_err_q;
      pass_d      = 1'b0;
      fail_d      = 1'b1;
      lfsr_pause  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      first_err_q <= '0;
      err_q       <= 8'd0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      first_err_q <= first_err_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FINISH);
  assign wr_req         = (state_q == S_WRITE);
  assign rd_req         = (state_q == S_READ);
  assign lfsr_load      = (state_q == S_REWIND);
  assign lfsr_enable    = busy;
  assign lfsr_ldata     = SEED;
  assign wr_data        = lfsr_data;
  assign mem_addr       = addr_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign err_count      = err_q;
  assign first_err_addr = first_err_q;

endmodule
